// File: rtl/alu_pkg.sv
// Shared op map, op-class codes, FSM state and flag bundle for the execute-stage ALU.
package alu_pkg;

  localparam logic [1:0] CLASS_FUNCT = 2'd1;
  localparam logic [1:0] CLASS_OPC   = 2'd2;

  localparam logic [5:0] FUNCT_ADD  = 6'd0;
  localparam logic [5:0] FUNCT_ADDI = 6'd1;
  localparam logic [5:0] FUNCT_SUB  = 6'd2;
  localparam logic [5:0] FUNCT_SUBI = 6'd3;
  localparam logic [5:0] FUNCT_AND  = 6'd4;
  localparam logic [5:0] FUNCT_ANDI = 6'd5;
  localparam logic [5:0] FUNCT_OR   = 6'd6;
  localparam logic [5:0] FUNCT_ORI  = 6'd7;
  localparam logic [5:0] FUNCT_XOR  = 6'd8;
  localparam logic [5:0] FUNCT_NOR  = 6'd9;
  localparam logic [5:0] FUNCT_NOT  = 6'd10;
  localparam logic [5:0] FUNCT_SLT  = 6'd11;
  localparam logic [5:0] FUNCT_SLE  = 6'd12;
  localparam logic [5:0] FUNCT_SGT  = 6'd13;
  localparam logic [5:0] FUNCT_SGE  = 6'd14;
  localparam logic [5:0] FUNCT_EQ   = 6'd15;
  localparam logic [5:0] FUNCT_NEQ  = 6'd16;
  localparam logic [5:0] FUNCT_MUL  = 6'd17;
  localparam logic [5:0] FUNCT_DIV  = 6'd18;

  localparam logic [5:0] OPC_SRL = 6'd4;
  localparam logic [5:0] OPC_SLL = 6'd5;
  localparam logic [5:0] OPC_BEQ = 6'd6;
  localparam logic [5:0] OPC_BNQ = 6'd7;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DIV  = 2'd1,
    HOLD = 2'd2
  } state_t;

  typedef struct packed {
    logic branch_taken;
    logic div_by_zero;
    logic illegal_op;
  } flags_t;

endpackage

// File: rtl/alu_serial_divider.sv
// Restoring shift-subtract divider, one quotient bit per cycle.
// Latency: WIDTH cycles after start; done flags the final iteration, quotient valid with it.
// Backpressure: none; start is only honoured by the caller when idle.
module alu_serial_divider #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient
);

  localparam int CW = $clog2(WIDTH);

  logic             busy_q, busy_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] dvsr_q, dvsr_d;
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH:0]   diff;
  logic             q_bit;

  // Remainder stays below the divisor, so bit WIDTH of diff is a clean borrow.
  always_comb begin
    rem_sh = {rem_q, quo_q[WIDTH-1]};
    diff   = rem_sh - {1'b0, dvsr_q};
    q_bit  = ~diff[WIDTH];
    busy_d = busy_q;
    cnt_d  = cnt_q;
    rem_d  = rem_q;
    quo_d  = quo_q;
    dvsr_d = dvsr_q;
    if (start) begin
      busy_d = 1'b1;
      cnt_d  = '0;
      rem_d  = '0;
      quo_d  = dividend;
      dvsr_d = divisor;
    end else if (busy_q) begin
      rem_d = q_bit ? diff[WIDTH-1:0] : rem_sh[WIDTH-1:0];
      quo_d = {quo_q[WIDTH-2:0], q_bit};
      cnt_d = cnt_q + CW'(1);
      if (cnt_q == CW'(WIDTH - 1)) begin
        busy_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      busy_q <= 1'b0;
      cnt_q  <= '0;
      rem_q  <= '0;
      quo_q  <= '0;
      dvsr_q <= '0;
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
      rem_q  <= rem_d;
      quo_q  <= quo_d;
      dvsr_q <= dvsr_d;
    end
  end

  assign busy     = busy_q;
  assign done     = busy_q & (cnt_q == CW'(WIDTH - 1));
  assign quotient = {quo_q[WIDTH-2:0], q_bit};

endmodule

// File: rtl/alu_multicycle_unit.sv
// Execute-stage ALU with valid/ready on both sides; iterative divide only when ALU_DIVIDER_EN is defined.
// Latency: 1 cycle for single-cycle ops, WIDTH cycles for divide.
// Backpressure: result held while out_valid & !out_ready; in_ready drops in DIV and in a stalled HOLD.
module alu_multicycle_unit
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       op_class,
  input  logic [5:0]       opcode,
  input  logic [5:0]       funct,
  input  logic [WIDTH-1:0] rs_value,
  input  logic [WIDTH-1:0] rt_value,
  input  logic [WIDTH-1:0] immediate,
  input  logic [SHW-1:0]   shamt,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] rd_value,
  output logic             branch_taken,
  output logic             zero,
  output logic             div_by_zero,
  output logic             illegal_op
);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] rd_q, rd_d;
  logic             zero_q, zero_d;
  flags_t           flags_q, flags_d;

  logic [WIDTH-1:0] sc_res;
  flags_t           sc_flags;
  logic             accept;
  logic             div_req;
  logic             div_busy;
  logic             div_done;
  logic [WIDTH-1:0] div_quotient;

  assign in_ready = reset_n & ~div_busy &
                    ((state_q == IDLE) | ((state_q == HOLD) & out_ready));
  assign accept   = in_valid & in_ready;

`ifdef ALU_DIVIDER_EN
  logic div_start;

  assign div_req   = (op_class == CLASS_FUNCT) && (funct == FUNCT_DIV) && (rt_value != '0);
  assign div_start = accept & div_req;

  alu_serial_divider #(
    .WIDTH(WIDTH)
  ) u_div (
    .clock   (clock),
    .reset_n (reset_n),
    .start   (div_start),
    .dividend(rs_value),
    .divisor (rt_value),
    .busy    (div_busy),
    .done    (div_done),
    .quotient(div_quotient)
  );
`else
  assign div_req      = 1'b0;
  assign div_busy     = 1'b0;
  assign div_done     = 1'b0;
  assign div_quotient = '0;
`endif

  always_comb begin
    sc_res   = '0;
    sc_flags = '0;
    case (op_class)
      CLASS_FUNCT: begin
        case (funct)
          FUNCT_ADD:  sc_res = rs_value + rt_value;
          FUNCT_ADDI: sc_res = rs_value + immediate;
          FUNCT_SUB:  sc_res = rs_value - rt_value;
          FUNCT_SUBI: sc_res = rs_value - immediate;
          FUNCT_AND:  sc_res = rs_value & rt_value;
          FUNCT_ANDI: sc_res = rs_value & immediate;
          FUNCT_OR:   sc_res = rs_value | rt_value;
          FUNCT_ORI:  sc_res = rs_value | immediate;
          FUNCT_XOR:  sc_res = rs_value ^ rt_value;
          FUNCT_NOR:  sc_res = ~(rs_value | rt_value);
          FUNCT_NOT:  sc_res = ~rs_value;
          FUNCT_SLT:  sc_res = WIDTH'(rs_value <  rt_value);
          FUNCT_SLE:  sc_res = WIDTH'(rs_value <= rt_value);
          FUNCT_SGT:  sc_res = WIDTH'(rs_value >  rt_value);
          FUNCT_SGE:  sc_res = WIDTH'(rs_value >= rt_value);
          FUNCT_EQ:   sc_res = WIDTH'(rs_value == rt_value);
          FUNCT_NEQ:  sc_res = WIDTH'(rs_value != rt_value);
          FUNCT_MUL:  sc_res = rs_value * rt_value;
          FUNCT_DIV: begin
`ifdef ALU_DIVIDER_EN
            // Non-zero divisors go to the serial divider; only the zero case resolves here.
            if (rt_value == '0) begin
              sc_res               = '1;
              sc_flags.div_by_zero = 1'b1;
            end
`else
            sc_flags.illegal_op = 1'b1;
`endif
          end
          default:    sc_flags.illegal_op = 1'b1;
        endcase
      end
      CLASS_OPC: begin
        case (opcode)
          OPC_SRL: sc_res = rs_value >> shamt;
          OPC_SLL: sc_res = rs_value << shamt;
          OPC_BEQ: sc_flags.branch_taken = (rs_value == rt_value);
          OPC_BNQ: sc_flags.branch_taken = (rs_value != rt_value);
          default: sc_flags.illegal_op = 1'b1;
        endcase
      end
      default: sc_flags.illegal_op = 1'b1;
    endcase
  end

  always_comb begin
    state_d = state_q;
    rd_d    = rd_q;
    zero_d  = zero_q;
    flags_d = flags_q;
    case (state_q)
      IDLE, HOLD: begin
        if (accept) begin
          if (div_req) begin
            state_d = DIV;
            rd_d    = '0;
            zero_d  = 1'b0;
            flags_d = '0;
          end else begin
            state_d = HOLD;
            rd_d    = sc_res;
            zero_d  = (sc_res == '0);
            flags_d = sc_flags;
          end
        end else if ((state_q == HOLD) && out_ready) begin
          state_d = IDLE;
        end
      end
      DIV: begin
        if (div_done) begin
          state_d = HOLD;
          rd_d    = div_quotient;
          zero_d  = (div_quotient == '0);
          flags_d = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      rd_q    <= '0;
      zero_q  <= 1'b0;
      flags_q <= '0;
    end else begin
      state_q <= state_d;
      rd_q    <= rd_d;
      zero_q  <= zero_d;
      flags_q <= flags_d;
    end
  end

  assign out_valid    = (state_q == HOLD);
  assign rd_value     = rd_q;
  assign zero         = zero_q;
  assign branch_taken = flags_q.branch_taken;
  assign div_by_zero  = flags_q.div_by_zero;
  assign illegal_op   = flags_q.illegal_op;

endmodule

// File: tb/tb_alu_multicycle_unit.sv
// Directed-vector bench for alu_multicycle_unit; covers both divider build options.
module tb_alu_multicycle_unit;
  import alu_pkg::*;

  localparam int W  = 32;
  localparam int SW = 5;

  logic          clock = 1'b0;
  logic          reset_n = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [1:0]    op_class = 2'd0;
  logic [5:0]    opcode = 6'd0;
  logic [5:0]    funct = 6'd0;
  logic [W-1:0]  rs_value = '0;
  logic [W-1:0]  rt_value = '0;
  logic [W-1:0]  immediate = '0;
  logic [SW-1:0] shamt = '0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [W-1:0]  rd_value;
  logic          branch_taken;
  logic          zero;
  logic          div_by_zero;
  logic          illegal_op;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  alu_multicycle_unit #(.WIDTH(W), .SHW(SW)) dut (
    .clock(clock), .reset_n(reset_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .op_class(op_class), .opcode(opcode), .funct(funct),
    .rs_value(rs_value), .rt_value(rt_value), .immediate(immediate), .shamt(shamt),
    .out_valid(out_valid), .out_ready(out_ready), .rd_value(rd_value),
    .branch_taken(branch_taken), .zero(zero), .div_by_zero(div_by_zero), .illegal_op(illegal_op)
  );

  typedef struct {
    logic [1:0]    cls;
    logic [5:0]    code;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic [W-1:0]  im;
    logic [SW-1:0] sh;
    logic [W-1:0]  exp;
    logic          br;
  } vec_t;

  task automatic drive(input logic [1:0] c, input logic [5:0] code, input logic [W-1:0] a,
                       input logic [W-1:0] b, input logic [W-1:0] im, input logic [SW-1:0] sh);
    op_class  = c;
    funct     = code;
    opcode    = code;
    rs_value  = a;
    rt_value  = b;
    immediate = im;
    shamt     = sh;
    in_valid  = 1'b1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (2) @(negedge clock);
    checks++;
    if ({in_ready, out_valid, rd_value, branch_taken, zero, div_by_zero, illegal_op} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: in_ready=%b out_valid=%b rd=%h br=%b z=%b dbz=%b ill=%b, required all 0",
               in_ready, out_valid, rd_value, branch_taken, zero, div_by_zero, illegal_op);
    end
    reset_n = 1'b1;
    @(negedge clock);
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: in_ready=%b out_valid=%b, required 1/0", in_ready, out_valid);
    end
  endtask

  task automatic test_add_wrap();
    out_ready = 1'b1;
    drive(CLASS_FUNCT, FUNCT_ADD, 32'hFFFF_FFFF, 32'd1, '0, '0);
    @(negedge clock);
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || rd_value !== 32'd0 || zero !== 1'b1) begin
      errors++;
      $display("FAIL add_wrap: vld=%b rd=%h zero=%b, required 1/00000000/1", out_valid, rd_value, zero);
    end
    @(negedge clock);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL add_drain: out_valid=%b, required 0", out_valid);
    end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] exp [3];
    exp[0] = 32'd2; exp[1] = 32'd1; exp[2] = 32'd6;
    drive(CLASS_FUNCT, FUNCT_SUB, 32'd7, 32'd5, '0, '0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      checks++;
      if (out_valid !== 1'b1 || rd_value !== exp[i] || in_ready !== 1'b1) begin
        errors++;
        $display("FAIL b2b_%0d: vld=%b rd=%h in_ready=%b, required 1/%h/1", i, out_valid, rd_value, in_ready, exp[i]);
      end
      if (i == 0) drive(CLASS_FUNCT, FUNCT_SLT, 32'd3, 32'd5, '0, '0);
      else if (i == 1) drive(CLASS_FUNCT, FUNCT_XOR, 32'd3, 32'd5, '0, '0);
      else in_valid = 1'b0;
    end
    @(negedge clock);
  endtask

  task automatic test_op_table();
    vec_t v [22];
    v[0]  = '{CLASS_FUNCT, FUNCT_ADDI, 32'd10, 32'd0, 32'hFFFF_FFFF, 5'd0, 32'd9, 1'b0};
    v[1]  = '{CLASS_FUNCT, FUNCT_SUBI, 32'd0, 32'd0, 32'd1, 5'd0, 32'hFFFF_FFFF, 1'b0};
    v[2]  = '{CLASS_FUNCT, FUNCT_AND, 32'hF0F0, 32'hFF00, 32'd0, 5'd0, 32'h0000_F000, 1'b0};
    v[3]  = '{CLASS_FUNCT, FUNCT_ANDI, 32'h1234, 32'd0, 32'hFF, 5'd0, 32'h34, 1'b0};
    v[4]  = '{CLASS_FUNCT, FUNCT_OR, 32'hF0, 32'h0F, 32'd0, 5'd0, 32'hFF, 1'b0};
    v[5]  = '{CLASS_FUNCT, FUNCT_ORI, 32'h100, 32'd0, 32'd1, 5'd0, 32'h101, 1'b0};
    v[6]  = '{CLASS_FUNCT, FUNCT_NOR, 32'd0, 32'd0, 32'd0, 5'd0, 32'hFFFF_FFFF, 1'b0};
    v[7]  = '{CLASS_FUNCT, FUNCT_NOT, 32'h0000_FFFF, 32'd0, 32'd0, 5'd0, 32'hFFFF_0000, 1'b0};
    v[8]  = '{CLASS_FUNCT, FUNCT_SLE, 32'd5, 32'd5, 32'd0, 5'd0, 32'd1, 1'b0};
    v[9]  = '{CLASS_FUNCT, FUNCT_SGT, 32'd5, 32'd5, 32'd0, 5'd0, 32'd0, 1'b0};
    v[10] = '{CLASS_FUNCT, FUNCT_SGE, 32'd6, 32'd5, 32'd0, 5'd0, 32'd1, 1'b0};
    v[11] = '{CLASS_FUNCT, FUNCT_EQ, 32'd9, 32'd9, 32'd0, 5'd0, 32'd1, 1'b0};
    v[12] = '{CLASS_FUNCT, FUNCT_NEQ, 32'd9, 32'd9, 32'd0, 5'd0, 32'd0, 1'b0};
    v[13] = '{CLASS_FUNCT, FUNCT_SLT, 32'hFFFF_FFFF, 32'd1, 32'd0, 5'd0, 32'd0, 1'b0};
    v[14] = '{CLASS_FUNCT, FUNCT_MUL, 32'h1_0000, 32'h1_0001, 32'd0, 5'd0, 32'h0001_0000, 1'b0};
    v[15] = '{CLASS_FUNCT, FUNCT_MUL, 32'd7, 32'd6, 32'd0, 5'd0, 32'd42, 1'b0};
    v[16] = '{CLASS_OPC, OPC_SRL, 32'h8000_0000, 32'd0, 32'd0, 5'd31, 32'd1, 1'b0};
    v[17] = '{CLASS_OPC, OPC_SLL, 32'hFFFF_FFFF, 32'd0, 32'd0, 5'd31, 32'h8000_0000, 1'b0};
    v[18] = '{CLASS_OPC, OPC_BEQ, 32'd5, 32'd5, 32'd0, 5'd0, 32'd0, 1'b1};
    v[19] = '{CLASS_OPC, OPC_BEQ, 32'd3, 32'd4, 32'd0, 5'd0, 32'd0, 1'b0};
    v[20] = '{CLASS_OPC, OPC_BNQ, 32'd3, 32'd4, 32'd0, 5'd0, 32'd0, 1'b1};
    v[21] = '{CLASS_OPC, OPC_BNQ, 32'd4, 32'd4, 32'd0, 5'd0, 32'd0, 1'b0};
    out_ready = 1'b1;
    for (int i = 0; i <= 22; i++) begin
      if (i > 0) begin
        checks++;
        if (out_valid !== 1'b1 || rd_value !== v[i-1].exp || branch_taken !== v[i-1].br ||
            illegal_op !== 1'b0 || div_by_zero !== 1'b0) begin
          errors++;
          $display("FAIL op_table_%0d: vld=%b rd=%h br=%b ill=%b dbz=%b, required 1/%h/%b/0/0",
                   i - 1, out_valid, rd_value, branch_taken, illegal_op, div_by_zero, v[i-1].exp, v[i-1].br);
        end
      end
      if (i < 22) drive(v[i].cls, v[i].code, v[i].a, v[i].b, v[i].im, v[i].sh);
      else in_valid = 1'b0;
      @(negedge clock);
    end
  endtask

  task automatic test_illegal();
    logic [1:0] cls [4];
    logic [5:0] code [4];
    cls[0] = CLASS_FUNCT; code[0] = 6'd40;
    cls[1] = 2'd3;        code[1] = 6'd0;
    cls[2] = CLASS_OPC;   code[2] = 6'd9;
    cls[3] = 2'd0;        code[3] = 6'd4;
    for (int i = 0; i < 4; i++) begin
      drive(cls[i], code[i], 32'd7, 32'd7, 32'd7, 5'd1);
      @(negedge clock);
      checks++;
      if (out_valid !== 1'b1 || illegal_op !== 1'b1 || rd_value !== 32'd0 || branch_taken !== 1'b0) begin
        errors++;
        $display("FAIL illegal_%0d: vld=%b ill=%b rd=%h br=%b, required 1/1/00000000/0",
                 i, out_valid, illegal_op, rd_value, branch_taken);
      end
    end
    drive(CLASS_FUNCT, FUNCT_ADD, 32'd1, 32'd2, '0, '0);
    @(negedge clock);
    in_valid = 1'b0;
    checks++;
    if (illegal_op !== 1'b0 || rd_value !== 32'd3) begin
      errors++;
      $display("FAIL illegal_clear: ill=%b rd=%h, required 0/00000003", illegal_op, rd_value);
    end
    @(negedge clock);
  endtask

  task automatic test_div();
`ifdef ALU_DIVIDER_EN
    logic [W-1:0] a [2];
    logic [W-1:0] b [2];
    logic [W-1:0] q [2];
    int           lat;
    a[0] = 32'd100; b[0] = 32'd7;   q[0] = 32'd14;
    a[1] = 32'd7;   b[1] = 32'd100; q[1] = 32'd0;
    out_ready = 1'b1;
    for (int k = 0; k < 2; k++) begin
      lat = -1;
      drive(CLASS_FUNCT, FUNCT_DIV, a[k], b[k], '0, '0);
      for (int i = 0; i < W + 4; i++) begin
        @(negedge clock);
        in_valid = 1'b0;
        if (out_valid === 1'b1) begin
          lat = i;
          break;
        end
        checks++;
        if (in_ready !== 1'b0) begin
          errors++;
          $display("FAIL div_in_ready_%0d: cycle %0d in_ready=%b, required 0", k, i, in_ready);
        end
      end
      checks++;
      if (lat != W || rd_value !== q[k] || zero !== (q[k] == '0) || div_by_zero !== 1'b0) begin
        errors++;
        $display("FAIL div_%0d: latency=%0d rd=%h zero=%b dbz=%b, required %0d/%h/%b/0",
                 k, lat, rd_value, zero, div_by_zero, W, q[k], (q[k] == '0));
      end
      @(negedge clock);
    end
`else
    out_ready = 1'b1;
    drive(CLASS_FUNCT, FUNCT_DIV, 32'd100, 32'd7, '0, '0);
    @(negedge clock);
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || illegal_op !== 1'b1 || rd_value !== 32'd0) begin
      errors++;
      $display("FAIL div_disabled: vld=%b ill=%b rd=%h, required 1/1/00000000", out_valid, illegal_op, rd_value);
    end
    @(negedge clock);
`endif
  endtask

  task automatic test_div_zero();
    out_ready = 1'b1;
    drive(CLASS_FUNCT, FUNCT_DIV, 32'd55, 32'd0, '0, '0);
    @(negedge clock);
    checks++;
`ifdef ALU_DIVIDER_EN
    if (out_valid !== 1'b1 || rd_value !== 32'hFFFF_FFFF || div_by_zero !== 1'b1 || illegal_op !== 1'b0) begin
      errors++;
      $display("FAIL div_zero: vld=%b rd=%h dbz=%b ill=%b, required 1/ffffffff/1/0",
               out_valid, rd_value, div_by_zero, illegal_op);
    end
`else
    if (out_valid !== 1'b1 || rd_value !== 32'd0 || div_by_zero !== 1'b0 || illegal_op !== 1'b1) begin
      errors++;
      $display("FAIL div_zero: vld=%b rd=%h dbz=%b ill=%b, required 1/00000000/0/1",
               out_valid, rd_value, div_by_zero, illegal_op);
    end
`endif
    drive(CLASS_FUNCT, FUNCT_ADD, 32'd1, 32'd1, '0, '0);
    @(negedge clock);
    in_valid = 1'b0;
    checks++;
    if (rd_value !== 32'd2 || div_by_zero !== 1'b0 || illegal_op !== 1'b0) begin
      errors++;
      $display("FAIL div_zero_clear: rd=%h dbz=%b ill=%b, required 00000002/0/0", rd_value, div_by_zero, illegal_op);
    end
    @(negedge clock);
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    drive(CLASS_OPC, OPC_SLL, 32'd1, 32'd0, '0, 5'd4);
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      checks++;
      if (out_valid !== 1'b1 || rd_value !== 32'd16 || in_ready !== 1'b0 || zero !== 1'b0) begin
        errors++;
        $display("FAIL backpressure_%0d: vld=%b rd=%h in_ready=%b zero=%b, required 1/00000010/0/0",
                 i, out_valid, rd_value, in_ready, zero);
      end
      if (i == 0) drive(CLASS_FUNCT, FUNCT_ADD, 32'd5, 32'd5, '0, '0);
    end
    out_ready = 1'b1;
    @(negedge clock);
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || rd_value !== 32'd10) begin
      errors++;
      $display("FAIL backpressure_release: vld=%b rd=%h, required 1/0000000a", out_valid, rd_value);
    end
    @(negedge clock);
  endtask

  task automatic test_reset_mid_op();
    int seen;
    seen = 0;
`ifdef ALU_DIVIDER_EN
    out_ready = 1'b1;
    drive(CLASS_FUNCT, FUNCT_DIV, 32'd100, 32'd7, '0, '0);
    @(negedge clock);
    in_valid = 1'b0;
    repeat (9) @(negedge clock);
`else
    out_ready = 1'b0;
    drive(CLASS_FUNCT, FUNCT_ADD, 32'd5, 32'd5, '0, '0);
    @(negedge clock);
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || rd_value !== 32'd10) begin
      errors++;
      $display("FAIL pre_reset_hold: vld=%b rd=%h, required 1/0000000a", out_valid, rd_value);
    end
`endif
    reset_n = 1'b0;
    #1;
    checks++;
    if ({in_ready, out_valid, rd_value, branch_taken, zero, div_by_zero, illegal_op} !== '0) begin
      errors++;
      $display("FAIL mid_reset_outputs: in_ready=%b vld=%b rd=%h br=%b z=%b dbz=%b ill=%b, required all 0",
               in_ready, out_valid, rd_value, branch_taken, zero, div_by_zero, illegal_op);
    end
    @(negedge clock);
    reset_n = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < W + 4; i++) begin
      @(negedge clock);
      if (out_valid !== 1'b0) seen++;
    end
    checks++;
    if (seen != 0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL mid_reset_no_result: out_valid cycles=%0d in_ready=%b, required 0/1", seen, in_ready);
    end
  endtask

  initial begin
    #1;
    test_reset();
    test_add_wrap();
    test_back_to_back();
    test_op_table();
    test_illegal();
    test_div();
    test_div_zero();
    test_backpressure();
    test_reset_mid_op();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
